// File: rtl/pll_lock_sequencer_if.sv
// PLL supervisor signal bundle: PLL lock/reset handshake plus core-domain status.
// The master modport is the sequencer; the slave modport is the PLL/observer side.
interface pll_lock_sequencer_if #(
   parameter int unsigned RETRY_W = 2,
   parameter int unsigned LOST_W  = 4
);
   logic               pll_lock;
   logic               pll_resetb;
   logic               core_reset;
   logic               locked;
   logic               fail;
   logic [RETRY_W-1:0] retry_count;
   logic [LOST_W-1:0]  lost_count;

   modport master (
      input  pll_lock,
      output pll_resetb, core_reset, locked, fail, retry_count, lost_count
   );

   modport slave (
      output pll_lock,
      input  pll_resetb, core_reset, locked, fail, retry_count, lost_count
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Reset/lock supervisor for the PLL: pulses RESETB, waits for a stable lock with
// timeout and bounded retries, then releases the core reset; re-sequences on lock loss.
module pll_lock_sequencer #(
   parameter int unsigned PLL_RST_CYCLES = 21,
   parameter int unsigned LOCK_TIMEOUT   = 2100,
   parameter int unsigned LOCK_STABLE    = 210,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter int unsigned LOST_W         = 4
) (
   input logic clk,
   input logic reset,
   pll_lock_sequencer_if.master pll
);
   localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned CNT_MAX = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);

   typedef enum logic [2:0] {
      S_HOLD,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAIL
   } state_t;

   state_t             state_q, state_n;
   logic [1:0]         sync_q;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic [RETRY_W-1:0] retry_q, retry_n;
   logic [LOST_W-1:0]  lost_q, lost_n;
   logic               pll_resetb_q, pll_resetb_n;
   logic               core_reset_q, core_reset_n;
   logic               locked_q, locked_n;
   logic               fail_q, fail_n;
   logic               lock_s;

   assign lock_s = sync_q[1];

   // State, counters, synchroniser and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_HOLD;
         sync_q       <= '0;
         cnt_q        <= '0;
         retry_q      <= '0;
         lost_q       <= '0;
         pll_resetb_q <= 1'b0;
         core_reset_q <= 1'b1;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_n;
         sync_q       <= {sync_q[0], pll.pll_lock};
         cnt_q        <= cnt_n;
         retry_q      <= retry_n;
         lost_q       <= lost_n;
         pll_resetb_q <= pll_resetb_n;
         core_reset_q <= core_reset_n;
         locked_q     <= locked_n;
         fail_q       <= fail_n;
      end
   end

   // Next-state logic; outputs are decoded from the next state so they move with it.
   always_comb begin
      state_n = state_q;
      retry_n = retry_q;
      lost_n  = lost_q;
      cnt_n   = cnt_q;

      case (state_q)
         S_HOLD: begin
            if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_n = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            // A lock arriving on the timeout cycle takes priority over the retry.
            if (lock_s) begin
               state_n = S_STABLE;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               if (retry_q == RETRY_W'(MAX_RETRIES)) begin
                  state_n = S_FAIL;
               end else begin
                  retry_n = retry_q + RETRY_W'(1);
                  state_n = S_HOLD;
               end
            end
         end
         S_STABLE: begin
            if (!lock_s) state_n = S_WAIT_LOCK;
            else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) state_n = S_RUN;
         end
         S_RUN: begin
            if (!lock_s) begin
               state_n = S_HOLD;
               if (lost_q != '1) lost_n = lost_q + LOST_W'(1);
            end
         end
         S_FAIL: begin
            state_n = S_FAIL;
         end
         default: begin
            state_n = S_HOLD;
         end
      endcase

      if (state_n == S_RUN && state_q != S_RUN) retry_n = '0;

      if (state_n != state_q) cnt_n = '0;
      else if (state_q inside {S_HOLD, S_WAIT_LOCK, S_STABLE}) cnt_n = cnt_q + CNT_W'(1);

      pll_resetb_n = !(state_n inside {S_HOLD, S_FAIL});
      core_reset_n = (state_n != S_RUN);
      locked_n     = (state_n == S_RUN);
      fail_n       = (state_n == S_FAIL);
   end

   assign pll.pll_resetb  = pll_resetb_q;
   assign pll.core_reset  = core_reset_q;
   assign pll.locked      = locked_q;
   assign pll.fail        = fail_q;
   assign pll.retry_count = retry_q;
   assign pll.lost_count  = lost_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed/randomised bench for pll_lock_sequencer; expected timing is derived from
// the documented lock/timeout rules with plain arithmetic.
module tb_pll_lock_sequencer;
   localparam int unsigned RST_C   = 4;
   localparam int unsigned TMO     = 16;
   localparam int unsigned STB     = 8;
   localparam int unsigned MAXR    = 2;
   localparam int unsigned LW      = 4;
   localparam int unsigned RW      = $clog2(MAXR + 1);
   localparam int unsigned ATTEMPT = RST_C + TMO;
   // Ticks from raising pll_lock (while waiting) to the core_reset release edge.
   localparam int unsigned REL     = STB + 3;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   lost_exp = 0;

   pll_lock_sequencer_if #(.RETRY_W(RW), .LOST_W(LW)) bus ();

   pll_lock_sequencer #(
      .PLL_RST_CYCLES(RST_C), .LOCK_TIMEOUT(TMO), .LOCK_STABLE(STB),
      .MAX_RETRIES(MAXR), .LOST_W(LW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .pll  (bus.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals();
      chk("rst_resetb", 32'(bus.pll_resetb), 0);
      chk("rst_core",   32'(bus.core_reset), 1);
      chk("rst_locked", 32'(bus.locked), 0);
      chk("rst_fail",   32'(bus.fail), 0);
      chk("rst_retry",  32'(bus.retry_count), 0);
      chk("rst_lost",   32'(bus.lost_count), 0);
   endtask

   task automatic wait_resetb_high(input int exp);
      int n = 0;
      while (bus.pll_resetb !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("hold_len", 32'(n), 32'(exp));
   endtask

   task automatic expect_release(input int n, input int exp_retry);
      for (int i = 1; i <= n; i++) begin
         tick();
         if (i < n) begin
            chk("rel_core_held", 32'(bus.core_reset), 1);
            chk("rel_resetb",    32'(bus.pll_resetb), 1);
            chk("rel_retry",     32'(bus.retry_count), 32'(exp_retry));
         end else begin
            chk("rel_core_low",  32'(bus.core_reset), 0);
            chk("rel_locked",    32'(bus.locked), 1);
            chk("rel_retry_clr", 32'(bus.retry_count), 0);
            chk("rel_resetb_up", 32'(bus.pll_resetb), 1);
         end
      end
   endtask

   // Drop lock while running: HOLD two edges after the sampling edge.
   task automatic lose_lock();
      bus.pll_lock = 1'b0;
      tick();
      chk("loss_t0_core", 32'(bus.core_reset), 0);
      tick();
      chk("loss_t1_core", 32'(bus.core_reset), 0);
      tick();
      lost_exp = (lost_exp < 15) ? lost_exp + 1 : 15;
      chk("loss_core",   32'(bus.core_reset), 1);
      chk("loss_resetb", 32'(bus.pll_resetb), 0);
      chk("loss_locked", 32'(bus.locked), 0);
      chk("loss_lost",   32'(bus.lost_count), 32'(lost_exp));
      chk("loss_retry",  32'(bus.retry_count), 0);
   endtask

   task automatic bringup_after_hold(input int d);
      wait_resetb_high(RST_C);
      for (int i = 0; i < d; i++) tick();
      bus.pll_lock = 1'b1;
      expect_release(REL, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, g, len, r, er;
      reset = 1'b1;
      bus.pll_lock = 1'b0;
      tick();
      tick();
      check_reset_vals();
      reset = 1'b0;

      // Normal bring-up with a random lock delay inside the timeout window.
      d = int'($urandom_range(12, 0));
      bringup_after_hold(d);

      // Repeated loss in RUN; lost_count saturates at 15.
      for (int k = 0; k < 17; k++) begin
         lose_lock();
         bringup_after_hold(int'($urandom_range(6, 0)));
      end

      // Reset while running: sync flops clear, so lock_s needs two edges again.
      reset = 1'b1;
      tick();
      check_reset_vals();
      reset = 1'b0;
      lost_exp = 0;
      wait_resetb_high(RST_C);
      expect_release(STB + 1, 0);

      // Lock glitch inside STABLE forces a fresh full stability window, no retry.
      lose_lock();
      wait_resetb_high(RST_C);
      bus.pll_lock = 1'b1;
      g   = int'($urandom_range(5, 0));
      len = int'($urandom_range(3, 1));
      for (int i = 0; i < 3 + g; i++) begin
         tick();
         chk("glitch_pre_core", 32'(bus.core_reset), 1);
      end
      bus.pll_lock = 1'b0;
      for (int i = 0; i < len; i++) begin
         tick();
         chk("glitch_core",  32'(bus.core_reset), 1);
         chk("glitch_retry", 32'(bus.retry_count), 0);
      end
      bus.pll_lock = 1'b1;
      expect_release(REL, 0);

      // Lock reaching the FSM exactly on the timeout cycle.
      lose_lock();
      bringup_after_hold(TMO - 3);

      // Random number of timeouts before lock is finally achieved.
      lose_lock();
      r = int'($urandom_range(MAXR, 1));
      wait_resetb_high(RST_C);
      for (int a = 1; a <= r; a++) begin
         for (int i = 0; i < int'(TMO); i++) tick();
         chk("retry_hold_resetb", 32'(bus.pll_resetb), 0);
         chk("retry_cnt",         32'(bus.retry_count), 32'(a));
         wait_resetb_high(RST_C);
      end
      d = int'($urandom_range(12, 0));
      for (int i = 0; i < d; i++) tick();
      bus.pll_lock = 1'b1;
      expect_release(REL, r);

      // No lock ever: compare each cycle against the attempt/retry arithmetic.
      lose_lock();
      for (int c = 1; c <= 70; c++) begin
         tick();
         if (c >= int'((MAXR + 1) * ATTEMPT)) begin
            chk("nolock_fail",   32'(bus.fail), 1);
            chk("nolock_resetb", 32'(bus.pll_resetb), 0);
            er = int'(MAXR);
         end else begin
            chk("nolock_fail",   32'(bus.fail), 0);
            chk("nolock_resetb", 32'(bus.pll_resetb), 32'((c % int'(ATTEMPT)) >= int'(RST_C)));
            er = c / int'(ATTEMPT);
         end
         chk("nolock_retry", 32'(bus.retry_count), 32'(er));
         chk("nolock_core",  32'(bus.core_reset), 1);
         chk("nolock_lost",  32'(bus.lost_count), 32'(lost_exp));
      end

      // Reset out of FAIL clears the sticky flag and loss count, then re-sequences.
      reset = 1'b1;
      tick();
      check_reset_vals();
      reset = 1'b0;
      lost_exp = 0;
      bringup_after_hold(int'($urandom_range(12, 0)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
